mux_seven_segment_driver: RTL and testbench
===========================================

Name: mux_seven_segment_driver

Overview:
- Parametrised successor to the team's single-digit hex-to-seven-segment decoder.
- Drives an N-digit, time-multiplexed common-anode/cathode display from one packed hex value, with decimal points, blanking and a tear-free frame-synchronous load handshake.
- Sits between the datapath/status logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 1000, clocks per digit slot (>=2).
- SEG_ACTIVE_LOW, 1, 1: seg_out/dp_out driven low = lit.
- AN_ACTIVE_LOW, 1, 1: an_out driven low = digit enabled.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  request to display value_in/dp_in.
- value_in  input  4*NUM_DIGITS  packed hex digits; digit i = value_in[4i+3:4i], digit 0 least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- blank_en  input  1  1: all digits dark (scan continues).
- load_ack  output  1  one-cycle pulse when a load is committed.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, seg_out[0]=a.
- dp_out  output  1  decimal point of active digit.
- an_out  output  NUM_DIGITS  digit enables, an_out[i] for digit i.
- digit_idx  output  max(1,$clog2(NUM_DIGITS))  index of digit currently scanned.

Behaviour:
- Single clock domain; reset synchronous, active-high, named rst.
- Reset values: prescaler=0, digit_idx=0, display and shadow registers=0, pending=0, load_ack=0, an_out all inactive, seg_out and dp_out unlit (polarity per parameters).
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (count==REFRESH_DIV-1).
- On tick, digit_idx advances; NUM_DIGITS-1 wraps to 0. frame_end = tick && digit_idx==NUM_DIGITS-1.
- Load handshake:
  - load=1 captures value_in/dp_in into the shadow register and sets pending.
  - A later load before commit overwrites the shadow; the last one wins.
  - At frame_end with pending (or with load in the same cycle, which uses value_in directly), the display register <= shadow and pending clears.
  - load_ack=1 in the cycle after the commit edge, for exactly one cycle.
  - The displayed value never changes mid-frame.
- Decode, active-high before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Outputs are registered. At edge t+1 they reflect digit_idx, count and display register at cycle t, so latency is 1 clock.
- Dead time: when count==0, an_out is all inactive, to prevent ghosting. Otherwise only an_out[digit_idx] is active.
- blank_en=1: an_out all inactive, seg_out/dp_out unlit. Prescaler, scan and load commit continue.
- Reset mid-operation: pending load discarded, no load_ack, scan restarts at digit 0 with count 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits above the most significant non-zero digit of the display register are blanked (an_out inactive, dp still shown if its dp bit=1).
  - Digit 0 is always shown, so value 0 displays a single "0".
- When undefined: every digit is always shown, including zeros.

Decomposition:
- Package seg_display_pkg:
  - 16-entry hex-to-segment constant table.
  - Segment bit-position localparams.
  - Function for polarity application.
- One natural sub-module: seg_hex_decoder (combinational 4-bit to 7-bit lookup, no polarity), instantiated once on the muxed digit.

Test Plan:
- Reset: hold rst 3 cycles -> an_out=4'hF, seg_out=7'h7F, dp_out=1, load_ack=0, digit_idx=0 (defaults).
- Scan (REFRESH_DIV=4): run 32 cycles -> digit_idx cycles 0,1,2,3 every 4 clocks; an_out all 1 on each slot's first cycle, then 1110,1101,1011,0111.
- Load 0x12AF, dp_in=4'b0100 mid-frame -> no change until frame_end; load_ack pulse next cycle; digits show F:7'h0E, A:7'h08, 2:7'h24 with dp_out=0, 1:7'h79 (active-low).
- Two loads (0x1111 then 0x2222) in one frame -> only 0x2222 committed, exactly one load_ack.
- blank_en=1 for a full frame -> an_out stays 4'hF; a pending load still commits and acks at frame_end.
- LEADING_ZERO_BLANK_EN, load 0x0050 -> digits 3 and 2 never enabled; digit 1 shows 5; digit 0 shows 0. Assert rst mid-frame -> outputs return to reset values next cycle, no load_ack.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment vectors are {g,f,e,d,c,b,a}; table entries are active-high.
package seg_display_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;
    localparam int HEX_W = 4;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] seg_apply_pol(
        input logic [SEG_W-1:0] lit,
        input bit               active_low
    );
        return active_low ? ~lit : lit;
    endfunction

    function automatic logic bit_apply_pol(
        input logic lit,
        input bit   active_low
    );
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit to active-high segment pattern lookup.
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [HEX_W-1:0] hex,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = HEX_SEG_LUT[hex];
    end

endmodule

// File: rtl/mux_seven_segment_driver.sv
// N-digit multiplexed seven-segment driver with frame-synchronous load.
// Define LEADING_ZERO_BLANK_EN to suppress digits above the top non-zero one.
module mux_seven_segment_driver
    import seg_display_pkg::*;
#(
    parameter int  NUM_DIGITS     = 4,
    parameter int  REFRESH_DIV    = 1000,
    parameter bit  SEG_ACTIVE_LOW = 1'b1,
    parameter bit  AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [HEX_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        blank_en,
    output logic                        load_ack,
    output logic [SEG_W-1:0]            seg_out,
    output logic                        dp_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic [IDX_W-1:0]            digit_idx
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][HEX_W-1:0] digits_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    digits_t               shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
    logic                  pend_q, pend_d;
    digits_t               disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  ack_q, ack_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick;
    logic                  frame_end;
    logic [HEX_W-1:0]      cur_hex;
    logic [SEG_W-1:0]      cur_seg;
    logic                  lz_blank;
    logic                  seg_on;
    logic                  dp_on;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_vec;

    seg_hex_decoder u_dec (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        frame_end = tick && (idx_q == IDX_LAST);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        pend_d     = pend_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        ack_d      = 1'b0;

        if (load) begin
            shd_val_d = value_in;
            shd_dp_d  = dp_in;
            pend_d    = 1'b1;
        end
        // Commit only on frame boundaries so a frame never mixes two values.
        if (frame_end && (load || pend_q)) begin
            disp_val_d = load ? value_in : shd_val_q;
            disp_dp_d  = load ? dp_in : shd_dp_q;
            pend_d     = 1'b0;
            ack_d      = 1'b1;
        end
    end

    always_comb begin
        cur_hex = disp_val_q[idx_q];
        seg_on  = 1'b1;
        dp_on   = disp_dp_q[idx_q];
        an_on   = (cnt_q != '0);

`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic [IDX_W-1:0] msd;
            msd = '0;
            for (int i = 1; i < NUM_DIGITS; i++) begin
                if (disp_val_q[i] != '0) begin
                    msd = IDX_W'(i);
                end
            end
            lz_blank = (idx_q > msd);
        end
`else
        lz_blank = 1'b0;
`endif

        // A suppressed zero keeps its anode only to show a set decimal point.
        if (lz_blank) begin
            seg_on = 1'b0;
            an_on  = an_on && dp_on;
        end
        if (blank_en) begin
            seg_on = 1'b0;
            dp_on  = 1'b0;
            an_on  = 1'b0;
        end

        an_vec        = '0;
        an_vec[idx_q] = an_on;

        seg_d = seg_apply_pol(seg_on ? cur_seg : '0, SEG_ACTIVE_LOW);
        dp_d  = bit_apply_pol(dp_on, SEG_ACTIVE_LOW);
        an_d  = AN_ACTIVE_LOW ? ~an_vec : an_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shd_val_q  <= '0;
            shd_dp_q   <= '0;
            pend_q     <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            ack_q      <= 1'b0;
            seg_q      <= seg_apply_pol('0, SEG_ACTIVE_LOW);
            dp_q       <= bit_apply_pol(1'b0, SEG_ACTIVE_LOW);
            an_q       <= AN_ACTIVE_LOW ? '1 : '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shd_val_q  <= shd_val_d;
            shd_dp_q   <= shd_dp_d;
            pend_q     <= pend_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            ack_q      <= ack_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign load_ack  = ack_q;
    assign seg_out   = seg_q;
    assign dp_out    = dp_q;
    assign an_out    = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_mux_seven_segment_driver.sv
// Scoreboard bench for mux_seven_segment_driver (4 digits, 4 clocks/slot).
module tb_mux_seven_segment_driver;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int FRAME = N * R;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        blank_en;
    logic        load_ack;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;

    mux_seven_segment_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .blank_en  (blank_en),
        .load_ack  (load_ack),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [6:0] font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference state: cycles since reset, latest request, shown value.
    int          cyc;
    logic [15:0] m_shadow;
    logic [3:0]  m_shdp;
    bit          m_pend;
    logic [15:0] m_disp;
    logic [3:0]  m_dispdp;

    task automatic step();
        obs_t       e;
        int         slot;
        int         idx;
        int         msd;
        bit         lz;
        bit         lit;
        bit         en;
        bit         dpl;
        bit         commit;
        logic [6:0] segs;
        if (rst) begin
            e.idx = 2'd0;
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.ack = 1'b0;
            cyc      = 0;
            m_pend   = 0;
            m_shadow = '0;
            m_shdp   = '0;
            m_disp   = '0;
            m_dispdp = '0;
        end else begin
            slot = cyc % R;
            idx  = (cyc / R) % N;
            msd  = 0;
            lz   = 0;
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 1; i < N; i++) begin
                if (m_disp[4*i +: 4] != 4'h0) msd = i;
            end
            lz = (idx > msd);
`endif
            lit  = !blank_en;
            dpl  = lit && m_dispdp[idx];
            en   = lit && (slot != 0) && (!lz || m_dispdp[idx]);
            segs = (lit && !lz) ? font[m_disp[4*idx +: 4]] : 7'h00;
            e.idx = 2'(((cyc + 1) / R) % N);
            e.an  = en ? ~(4'b0001 << idx) : 4'hF;
            e.seg = ~segs;
            e.dp  = ~dpl;
            commit = ((cyc % FRAME) == FRAME - 1) && (m_pend || load);
            e.ack  = commit;
            if (load) begin
                m_shadow = value_in;
                m_shdp   = dp_in;
                m_pend   = 1;
            end
            if (commit) begin
                m_disp   = m_shadow;
                m_dispdp = m_shdp;
                m_pend   = 0;
            end
            cyc++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_to(input int ph);
        for (int k = 0; k < FRAME && (cyc % FRAME) != ph; k++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load     = 1'b1;
        value_in = v;
        dp_in    = d;
        step();
        load     = 1'b0;
    endtask

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {digit_idx, an_out, seg_out, dp_out, load_ack};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL out_check t=%0t got idx=%0d an=%b seg=%h dp=%b ack=%b required idx=%0d an=%b seg=%h dp=%b ack=%b",
                             $time, a.idx, a.an, a.seg, a.dp, a.ack,
                             e.idx, e.an, e.seg, e.dp, e.ack);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        blank_en = 1'b0;
        value_in = '0;
        dp_in    = '0;
        cyc      = 0;
        repeat (3) step();
        rst = 1'b0;
        repeat (32) step();

        run_to(5);
        do_load(16'h12AF, 4'b0100);
        repeat (40) step();

        run_to(2);
        do_load(16'h1111, 4'b0001);
        repeat (3) step();
        do_load(16'h2222, 4'b0010);
        repeat (36) step();

        run_to(1);
        do_load(16'hBEEF, 4'b1010);
        blank_en = 1'b1;
        repeat (FRAME + 2) step();
        blank_en = 1'b0;
        repeat (20) step();

        run_to(FRAME - 1);
        do_load(16'h3C0D, 4'b1001);
        repeat (20) step();

        run_to(6);
        do_load(16'h7777, 4'b0000);
        run_to(FRAME - 1);
        do_load(16'h8899, 4'b1111);
        repeat (20) step();

        run_to(3);
        do_load(16'h4567, 4'b0011);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        do_load(16'h0050, 4'b0000);
        repeat (40) step();

        repeat (400) begin
            load     = ($urandom_range(0, 7) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_en = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            step();
        end
        rst      = 1'b0;
        load     = 1'b0;
        blank_en = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
